// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one 1-bit borrow cell reused LSB-first over WIDTH cycles,
// with a start/busy/done handshake and registered result and final borrow.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             c_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   b_q, b_n;
  logic               borrow_q, borrow_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic [WIDTH-1:0]   diff_n;
  logic               c_out_n;
  logic               busy_n;
  logic               done_n;

  logic               a_bit, b_bit;
  logic               cell_d, cell_bout;

  // Operand bit selection for the current count (decoded to keep index widths exact)
  always_comb begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (count_q == CNT_W'(i)) begin
        a_bit = a_q[i];
        b_bit = b_q[i];
      end
    end
  end

  // The single shared 1-bit subtractor cell
  assign cell_d    = a_bit ^ b_bit ^ borrow_q;
  assign cell_bout = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    a_n      = a_q;
    b_n      = b_q;
    borrow_n = borrow_q;
    count_n  = count_q;
    diff_n   = diff;
    c_out_n  = c_out;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          a_n      = x;
          b_n      = y;
          borrow_n = 1'b0;
          count_n  = '0;
          state_n  = RUN;
          busy_n   = 1'b1;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (count_q == CNT_W'(i)) begin
            diff_n[i] = cell_d;
          end
        end
        borrow_n = cell_bout;
        count_n  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          c_out_n = cell_bout;
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          busy_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      diff     <= '0;
      c_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      a_q      <= a_n;
      b_q      <= b_n;
      borrow_q <= borrow_n;
      count_q  <= count_n;
      diff     <= diff_n;
      c_out    <= c_out_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random bench for serial_subtractor_ctrl at WIDTH=8: latency, handshake,
// reset abort, start-held-high spacing, and results against an unsigned subtract model.
module tb_serial_subtractor_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         c_out;

  int checks;
  int errors;

  logic [W-1:0] xs [30];
  logic [W-1:0] ys [30];

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic run_op(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic [W-1:0] exp_d, input logic exp_c);
    int lat;
    int nbusy;
    x     = xv;
    y     = yv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      x = W'($urandom);
      y = W'($urandom);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd9);
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'd8);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " diff"}, 32'(diff), 32'(exp_d));
    chk({tag, " c_out"}, 32'(c_out), 32'(exp_c));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " diff_hold"}, 32'(diff), 32'(exp_d));
  endtask

  initial begin
    logic [W:0] ref_r;
    logic [W-1:0] rx, ry;
    int seen_done;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    x      = '0;
    y      = '0;

    // Reset for two cycles
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset c_out", 32'(c_out), 32'd0);
    rst = 1'b0;

    // Directed vectors
    run_op("d05_03", 8'h05, 8'h03, 8'h02, 1'b0);
    run_op("d03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
    run_op("d00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op("dFF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
    run_op("s00_00", 8'h00, 8'h00, 8'h00, 1'b0);
    run_op("s00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op("s01_00", 8'h01, 8'h00, 8'h01, 1'b0);
    run_op("s01_01", 8'h01, 8'h01, 8'h00, 1'b0);

    // start held high with new operands every cycle: accepts at cycles 0,10,20
    for (int k = 0; k < 30; k++) begin
      xs[k] = W'($urandom);
      ys[k] = W'($urandom);
    end
    for (int k = 0; k < 30; k++) begin
      x     = xs[k];
      y     = ys[k];
      start = 1'b1;
      @(negedge clk);
      chk("held done", 32'(done), ((k % 10) == 8) ? 32'd1 : 32'd0);
      chk("held busy", 32'(busy), ((k % 10) <= 7) ? 32'd1 : 32'd0);
      if ((k % 10) == 8) begin
        ref_r = {1'b0, xs[k-8]} - {1'b0, ys[k-8]};
        chk("held diff", 32'(diff), 32'(ref_r[W-1:0]));
        chk("held c_out", 32'(c_out), 32'(ref_r[W]));
      end
    end
    start = 1'b0;

    // Reset on the fourth RUN cycle aborts the operation
    run_op("pre_abort", 8'h03, 8'h05, 8'hFE, 1'b1);
    x     = 8'h77;
    y     = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort diff", 32'(diff), 32'd0);
    chk("abort c_out", 32'(c_out), 32'd0);
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    chk("abort no_done", 32'(seen_done), 32'd0);
    run_op("post_abort", 8'h10, 8'h01, 8'h0F, 1'b0);

    // Random operand pairs against the unsigned subtract reference
    for (int n = 0; n < 1000; n++) begin
      rx    = W'($urandom);
      ry    = W'($urandom);
      ref_r = {1'b0, rx} - {1'b0, ry};
      run_op("rand", rx, ry, ref_r[W-1:0], ref_r[W]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
